// File: rtl/flag_update_stage.sv
// Flag-update pipeline stage: captures ALU outcome from EX and writes N/V/Z into the
// flag register one cycle later. A shadow copy supplies the bits a partial update leaves alone.
module flag_update_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic [3:0]       ex_opcode,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             stall,
    input  logic             flush,
    output logic [2:0]       flag_d,
    output logic             flag_we,
    output logic             flag_pending,
    output logic [2:0]       fwd_flags
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;

    logic       stg_valid_reg;
    logic [2:0] stg_flags_reg;
    logic [2:0] stg_mask_reg;
    logic [2:0] shadow_reg;

    logic [2:0] mask_next;
    logic [2:0] flags_next;
    logic       capture;
    logic       a_msb;
    logic       b_msb;
    logic       r_msb;

    assign a_msb = alu_a[WIDTH-1];
    assign b_msb = alu_b[WIDTH-1];
    assign r_msb = alu_result[WIDTH-1];

    always_comb begin
        mask_next     = 3'b000;
        flags_next    = 3'b000;
        flags_next[2] = r_msb;
        flags_next[0] = (alu_result == '0);
        unique case (ex_opcode)
            OP_ADD: begin
                mask_next     = 3'b111;
                flags_next[1] = (a_msb == b_msb) && (r_msb != a_msb);
            end
            OP_SUB: begin
                mask_next     = 3'b111;
                flags_next[1] = (a_msb != b_msb) && (r_msb != a_msb);
            end
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: mask_next = 3'b001;
            default: mask_next = 3'b000;
        endcase
    end

    assign capture = ex_valid && !stall && !flush && (mask_next != 3'b000);
    assign flag_we = stg_valid_reg && !stall;

    // Per-bit merge: bits outside the update mask keep the architectural value.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_merge
            assign flag_d[gi] = stg_mask_reg[gi] ? stg_flags_reg[gi] : shadow_reg[gi];
        end
    endgenerate

    assign flag_pending = stg_valid_reg;
    assign fwd_flags    = stg_valid_reg ? flag_d : shadow_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid_reg <= 1'b0;
            stg_flags_reg <= 3'b000;
            stg_mask_reg  <= 3'b000;
            shadow_reg    <= 3'b000;
        end else begin
            // A new capture may coincide with the commit of the older entry.
            if (capture) begin
                stg_valid_reg <= 1'b1;
                stg_flags_reg <= flags_next;
                stg_mask_reg  <= mask_next;
            end else if (flag_we) begin
                stg_valid_reg <= 1'b0;
            end
            if (flag_we) begin
                shadow_reg <= flag_d;
            end
        end
    end

endmodule

// File: tb/tb_flag_update_stage.sv
// Directed bench for flag_update_stage: one task per scenario, inline checks,
// one line printed per transaction.
module tb_flag_update_stage;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic        stall;
    logic        flush;
    logic [2:0]  flag_d;
    logic        flag_we;
    logic        flag_pending;
    logic [2:0]  fwd_flags;

    int checks;
    int failures;

    flag_update_stage #(.WIDTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_opcode    (ex_opcode),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .stall        (stall),
        .flush        (flush),
        .flag_d       (flag_d),
        .flag_we      (flag_we),
        .flag_pending (flag_pending),
        .fwd_flags    (fwd_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] r);
        ex_valid   = v;
        ex_opcode  = op;
        alu_a      = a;
        alu_b      = b;
        alu_result = r;
        $display("drive valid=%b op=%b a=%h b=%h r=%h stall=%b flush=%b", v, op, a, b, r, stall, flush);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 4'b1111, 16'h0, 16'h0, 16'h0);
        #2 rst_n = 1'b0;
        tick();
        tick();
        checks++; if (flag_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", flag_we); end
        checks++; if (flag_pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", flag_pending); end
        checks++; if (flag_d !== 3'b000) begin failures++; $display("FAIL reset_flag_d got=%b exp=000", flag_d); end
        checks++; if (fwd_flags !== 3'b000) begin failures++; $display("FAIL reset_fwd got=%b exp=000", fwd_flags); end
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_add_overflow();
        drive(1'b1, 4'b0000, 16'h7FFF, 16'h0001, 16'h8000);
        tick();
        drive(1'b0, 4'b0000, 16'h0, 16'h0, 16'h0);
        checks++; if (flag_we !== 1'b1) begin failures++; $display("FAIL add_we got=%b exp=1", flag_we); end
        checks++; if (flag_d !== 3'b110) begin failures++; $display("FAIL add_flag_d got=%b exp=110", flag_d); end
        checks++; if (fwd_flags !== 3'b110) begin failures++; $display("FAIL add_fwd got=%b exp=110", fwd_flags); end
        tick();
        checks++; if (flag_we !== 1'b0) begin failures++; $display("FAIL add_idle_we got=%b exp=0", flag_we); end
        checks++; if (flag_pending !== 1'b0) begin failures++; $display("FAIL add_idle_pending got=%b exp=0", flag_pending); end
        checks++; if (fwd_flags !== 3'b110) begin failures++; $display("FAIL add_shadow got=%b exp=110", fwd_flags); end
    endtask

    task automatic test_partial_merge();
        drive(1'b1, 4'b0010, 16'h1234, 16'h1234, 16'h0000);
        tick();
        checks++; if (flag_d !== 3'b111) begin failures++; $display("FAIL xor_merge got=%b exp=111", flag_d); end
        drive(1'b1, 4'b0100, 16'h0001, 16'h0002, 16'h0004);
        tick();
        drive(1'b0, 4'b0000, 16'h0, 16'h0, 16'h0);
        checks++; if (flag_we !== 1'b1) begin failures++; $display("FAIL sll_we got=%b exp=1", flag_we); end
        checks++; if (flag_d !== 3'b110) begin failures++; $display("FAIL sll_merge got=%b exp=110", flag_d); end
        tick();
        checks++; if (fwd_flags !== 3'b110) begin failures++; $display("FAIL sll_shadow got=%b exp=110", fwd_flags); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 4'b0001, 16'h0005, 16'h0005, 16'h0000);
        tick();
        checks++; if (flag_we !== 1'b1) begin failures++; $display("FAIL b2b_sub_we got=%b exp=1", flag_we); end
        checks++; if (flag_d !== 3'b001) begin failures++; $display("FAIL b2b_sub_flag_d got=%b exp=001", flag_d); end
        drive(1'b1, 4'b0000, 16'h0001, 16'h0002, 16'h0003);
        tick();
        drive(1'b0, 4'b0000, 16'h0, 16'h0, 16'h0);
        checks++; if (flag_we !== 1'b1) begin failures++; $display("FAIL b2b_add_we got=%b exp=1", flag_we); end
        checks++; if (flag_d !== 3'b000) begin failures++; $display("FAIL b2b_add_flag_d got=%b exp=000", flag_d); end
        tick();
        checks++; if (flag_we !== 1'b0) begin failures++; $display("FAIL b2b_idle_we got=%b exp=0", flag_we); end
        checks++; if (fwd_flags !== 3'b000) begin failures++; $display("FAIL b2b_shadow got=%b exp=000", fwd_flags); end
    endtask

    task automatic test_stall();
        // ADD FFFF+FFFF=FFFE: N=1, no overflow, nonzero
        drive(1'b1, 4'b0000, 16'hFFFF, 16'hFFFF, 16'hFFFE);
        tick();
        stall = 1'b1;
        // a valid XOR sits in EX during the stall and must not be captured
        drive(1'b1, 4'b0010, 16'h0000, 16'h0000, 16'h0000);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (flag_we !== 1'b0) begin failures++; $display("FAIL stall_we[%0d] got=%b exp=0", i, flag_we); end
            checks++; if (flag_pending !== 1'b1) begin failures++; $display("FAIL stall_pending[%0d] got=%b exp=1", i, flag_pending); end
            checks++; if (flag_d !== 3'b100) begin failures++; $display("FAIL stall_flag_d[%0d] got=%b exp=100", i, flag_d); end
            tick();
        end
        stall = 1'b0;
        drive(1'b0, 4'b0000, 16'h0, 16'h0, 16'h0);
        #1;
        checks++; if (flag_we !== 1'b1) begin failures++; $display("FAIL stall_release_we got=%b exp=1", flag_we); end
        checks++; if (flag_d !== 3'b100) begin failures++; $display("FAIL stall_release_flag_d got=%b exp=100", flag_d); end
        tick();
        checks++; if (flag_pending !== 1'b0) begin failures++; $display("FAIL stall_done_pending got=%b exp=0", flag_pending); end
        checks++; if (fwd_flags !== 3'b100) begin failures++; $display("FAIL stall_shadow got=%b exp=100", fwd_flags); end
    endtask

    task automatic test_flush();
        drive(1'b1, 4'b0000, 16'h0001, 16'h0001, 16'h0002);
        tick();
        checks++; if (flag_d !== 3'b000) begin failures++; $display("FAIL flush_add_flag_d got=%b exp=000", flag_d); end
        flush = 1'b1;
        // SUB 8000-0001=7FFF would give 010 if it were captured
        drive(1'b1, 4'b0001, 16'h8000, 16'h0001, 16'h7FFF);
        tick();
        flush = 1'b0;
        drive(1'b0, 4'b0000, 16'h0, 16'h0, 16'h0);
        checks++; if (flag_we !== 1'b0) begin failures++; $display("FAIL flush_we got=%b exp=0", flag_we); end
        checks++; if (flag_pending !== 1'b0) begin failures++; $display("FAIL flush_pending got=%b exp=0", flag_pending); end
        checks++; if (fwd_flags !== 3'b000) begin failures++; $display("FAIL flush_shadow got=%b exp=000", fwd_flags); end
        drive(1'b1, 4'b1000, 16'h0000, 16'h0000, 16'h0000);
        tick();
        drive(1'b0, 4'b0000, 16'h0, 16'h0, 16'h0);
        checks++; if (flag_pending !== 1'b0) begin failures++; $display("FAIL op1000_pending got=%b exp=0", flag_pending); end
        checks++; if (flag_we !== 1'b0) begin failures++; $display("FAIL op1000_we got=%b exp=0", flag_we); end
        // stall and flush together: older entry held, EX instruction dropped
        drive(1'b1, 4'b0001, 16'h8000, 16'h0001, 16'h7FFF);
        tick();
        stall = 1'b1;
        flush = 1'b1;
        drive(1'b1, 4'b0010, 16'h0000, 16'h0000, 16'h0000);
        tick();
        checks++; if (flag_pending !== 1'b1) begin failures++; $display("FAIL stflush_pending got=%b exp=1", flag_pending); end
        checks++; if (flag_we !== 1'b0) begin failures++; $display("FAIL stflush_we got=%b exp=0", flag_we); end
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 4'b0000, 16'h0, 16'h0, 16'h0);
        #1;
        checks++; if (flag_d !== 3'b010) begin failures++; $display("FAIL stflush_flag_d got=%b exp=010", flag_d); end
        tick();
        checks++; if (fwd_flags !== 3'b010) begin failures++; $display("FAIL stflush_shadow got=%b exp=010", fwd_flags); end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 4'b0000, 16'h7FFF, 16'h0001, 16'h8000);
        tick();
        drive(1'b0, 4'b0000, 16'h0, 16'h0, 16'h0);
        checks++; if (flag_pending !== 1'b1) begin failures++; $display("FAIL areset_pre_pending got=%b exp=1", flag_pending); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (flag_we !== 1'b0) begin failures++; $display("FAIL areset_we got=%b exp=0", flag_we); end
        checks++; if (flag_pending !== 1'b0) begin failures++; $display("FAIL areset_pending got=%b exp=0", flag_pending); end
        checks++; if (flag_d !== 3'b000) begin failures++; $display("FAIL areset_flag_d got=%b exp=000", flag_d); end
        checks++; if (fwd_flags !== 3'b000) begin failures++; $display("FAIL areset_fwd got=%b exp=000", fwd_flags); end
        #1 rst_n = 1'b1;
        tick();
        checks++; if (flag_we !== 1'b0) begin failures++; $display("FAIL areset_post_we got=%b exp=0", flag_we); end
        checks++; if (fwd_flags !== 3'b000) begin failures++; $display("FAIL areset_post_fwd got=%b exp=000", fwd_flags); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_add_overflow();
        test_partial_merge();
        test_back_to_back();
        test_stall();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
